muldiv_seq_ctrl: RTL and testbench

// - Sequences the multi-cycle MULT/MULTU/DIV/DIVU operations selected by the ALU decoder's alucontrol codes in the execute stage.
// - Runs an iterative shift-add multiplier or a restoring divider and stalls the pipeline while busy.
// - Delivers the 64-bit {HI,LO} result to the HI/LO register write path for exactly one cycle.

---
 rtl/muldiv_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: shift-add multiplier and restoring divider with pipeline stall.
// Optional MULDIV_EARLY_ZERO_EN: zero-operand MUL and divide-by-zero skip straight to DONE.
`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b11000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b11001
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b11011
`endif

module muldiv_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [4:0]       alucontrol_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div, is_sgn, neg_a, neg_b, done_q;
  logic [W2-1:0]    acc, acc_nxt;
  logic [WIDTH-1:0] opb;

  logic             op_mul, op_div, op_sgn, accept, early_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             div_ge, sgn_diff, div0;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix, res_hi, res_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic c, input logic [WIDTH-1:0] v);
    return c ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] neg_w2(input logic c, input logic [W2-1:0] v);
    return c ? (~v + W2'(1)) : v;
  endfunction

  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
    case (alucontrol_i)
      `MULT_CONTROL:  begin op_mul = 1'b1; op_sgn = 1'b1; end
      `MULTU_CONTROL: op_mul = 1'b1;
      `DIV_CONTROL:   begin op_div = 1'b1; op_sgn = 1'b1; end
      `DIVU_CONTROL:  op_div = 1'b1;
      default: ;
    endcase
  end

  assign accept  = (state == IDLE) && start_i && (op_mul || op_div) && !flush_i;
  assign stall_o = resetn && !flush_i && (accept || (state == BUSY));
  assign done_o  = done_q && !flush_i;

  assign mag_a = neg_w(op_sgn & srca_i[WIDTH-1], srca_i);
  assign mag_b = neg_w(op_sgn & srcb_i[WIDTH-1], srcb_i);

`ifdef MULDIV_EARLY_ZERO_EN
  assign early_zero = op_div ? (srcb_i == '0) : ((srca_i == '0) || (srcb_i == '0));
`else
  assign early_zero = 1'b0;
`endif

  // One iteration: shift-add for MUL, compare-subtract on the widened remainder for DIV
  assign mul_sum = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
  assign rem_sh  = acc[W2-1:WIDTH-1];
  assign rem_sub = rem_sh[WIDTH-1:0] - opb;
  assign div_ge  = rem_sh >= {1'b0, opb};

  always_comb begin
    if (!is_div)
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (div_ge)
      acc_nxt = {rem_sub, acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign correction; a zero divisor keeps the all-ones quotient and the raw dividend as remainder
  assign sgn_diff = is_sgn & (neg_a ^ neg_b);
  assign div0     = (opb == '0);
  assign prod_fix = neg_w2(sgn_diff, acc_nxt);
  assign q_fix    = neg_w(sgn_diff & ~div0, acc_nxt[WIDTH-1:0]);
  assign r_fix    = neg_w(is_sgn & neg_a, acc_nxt[W2-1:WIDTH]);
  assign res_hi   = is_div ? r_fix : prod_fix[W2-1:WIDTH];
  assign res_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      done_q <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            is_div <= op_div;
            is_sgn <= op_sgn;
            neg_a  <= op_sgn & srca_i[WIDTH-1];
            neg_b  <= op_sgn & srcb_i[WIDTH-1];
            cnt    <= '0;
            if (early_zero) begin
              state  <= DONE;
              done_q <= 1'b1;
              hi_o   <= op_div ? srca_i : '0;
              lo_o   <= op_div ? '1 : '0;
            end else begin
              state <= BUSY;
            end
          end
          BUSY: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state  <= DONE;
              done_q <= 1'b1;
              hi_o   <= res_hi;
              lo_o   <= res_lo;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc <= {WIDTH'(0), (op_div ? mag_a : mag_b)};
      opb <= op_div ? mag_b : mag_a;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed and randomized bench for muldiv_seq_ctrl against an arithmetic reference model.
`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b11000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b11001
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b11011
`endif

module tb_muldiv_seq_ctrl;
  localparam logic [4:0] ADDU_CODE = 5'b00010;

  logic        clk = 1'b0;
  logic        resetn, flush_i, start_i;
  logic [4:0]  alucontrol_i;
  logic [31:0] srca_i, srcb_i;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  muldiv_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush_i(flush_i), .start_i(start_i),
    .alucontrol_i(alucontrol_i), .srca_i(srca_i), .srcb_i(srcb_i),
    .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands
  task automatic model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0]        ua, ub, up;
    logic signed [63:0] sa, sb, sr;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    hi = '0;
    lo = '0;
    if (code == `MULT_CONTROL) begin
      sr = sa * sb;
      hi = sr[63:32];
      lo = sr[31:0];
    end else if (code == `MULTU_CONTROL) begin
      up = ua * ub;
      hi = up[63:32];
      lo = up[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (code == `DIV_CONTROL) begin
      sr = sa / sb;
      lo = sr[31:0];
      sr = sa % sb;
      hi = sr[31:0];
    end else begin
      up = ua / ub;
      lo = up[31:0];
      up = ua % ub;
      hi = up[31:0];
    end
  endtask

  function automatic bit early_of(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    bit z;
    z = (code == `DIV_CONTROL || code == `DIVU_CONTROL) ? (b == 32'd0) : (a == 32'd0 || b == 32'd0);
`ifdef MULDIV_EARLY_ZERO_EN
    return z;
`else
    return z & 1'b0;
`endif
  endfunction

  // Called just after a rising edge; that cycle is cycle 0 of the operation.
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int flush_at, input bit hold);
    int lat;
    bit fl;
    lat = early_of(code, a, b) ? 1 : 33;
    start_i = 1'b1;
    alucontrol_i = code;
    srca_i = a;
    srcb_i = b;
    for (int c = 0; c <= lat; c++) begin
      flush_i = (c == flush_at);
      @(negedge clk);
      fl = (flush_at >= 0) && (c >= flush_at);
      check("stall", 32'(stall_o), 32'(!fl && c < lat));
      check("done", 32'(done_o), 32'(!fl && c == lat));
      if (c == lat && !fl) begin
        check("hi", hi_o, exp_hi);
        check("lo", lo_o, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
      end
      if (c == flush_at) begin
        check("hi_hold", hi_o, model_hi);
        check("lo_hold", lo_o, model_lo);
      end
      @(posedge clk);
      #1;
      if (!hold) start_i = 1'b0;
      if (c == flush_at) break;
    end
    flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall", 32'(stall_o), 32'd0);
      check("idle_done", 32'(done_o), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [4:0]  codes [4];
    logic [4:0]  code;
    logic [31:0] a, b, eh, el;
    int          r;
    codes[0] = `MULT_CONTROL;
    codes[1] = `MULTU_CONTROL;
    codes[2] = `DIV_CONTROL;
    codes[3] = `DIVU_CONTROL;

    resetn = 1'b0;
    flush_i = 1'b0;
    start_i = 1'b0;
    alucontrol_i = '0;
    srca_i = '0;
    srcb_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run_op(`MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, 1'b0);
    run_op(`MULT_CONTROL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, 1'b0);
    run_op(`DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 1'b0);
    run_op(`DIVU_CONTROL, 32'd100, 32'd7, 32'd2, 32'd14, -1, 1'b0);
    run_op(`DIVU_CONTROL, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(`DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1, 1'b0);
    run_op(`DIV_CONTROL, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, 1'b0);
    run_op(`MULT_CONTROL, 32'd0, 32'hFFFF_FFF0, 32'd0, 32'd0, -1, 1'b0);
    idle(1);

    // Flush in the middle of a divide; the next op is accepted right after
    run_op(`DIV_CONTROL, 32'd1000, 32'd3, 32'd1, 32'd333, 10, 1'b0);
    run_op(`MULTU_CONTROL, 32'd4, 32'd5, 32'd0, 32'd20, -1, 1'b0);

    // start_i held through BUSY/DONE, then back-to-back MULTU
    run_op(`DIVU_CONTROL, 32'd100, 32'd7, 32'd2, 32'd14, -1, 1'b1);
    run_op(`MULTU_CONTROL, 32'd2, 32'd3, 32'd0, 32'd6, -1, 1'b0);
    idle(2);

    // flush and start together in IDLE: nothing starts
    run_op(`MULT_CONTROL, 32'd7, 32'd9, 32'd0, 32'd63, 0, 1'b0);
    idle(3);
    check("flushstart_hi", hi_o, model_hi);
    check("flushstart_lo", lo_o, model_lo);

    // Non-mul/div code never stalls
    start_i = 1'b1;
    alucontrol_i = ADDU_CODE;
    srca_i = 32'd3;
    srcb_i = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("addu_stall", 32'(stall_o), 32'd0);
      check("addu_done", 32'(done_o), 32'd0);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;

    for (int n = 0; n < 24; n++) begin
      code = codes[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 7);
      if (r == 0) b = 32'd0;
      if (r == 1) a = 32'd0;
      if (r == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 3) b = $urandom_range(1, 15);
      model(code, a, b, eh, el);
      run_op(code, a, b, eh, el, -1, 1'b0);
    end

    // Asynchronous reset in cycle 15 of a MULT
    start_i = 1'b1;
    alucontrol_i = `MULT_CONTROL;
    srca_i = 32'h0001_2345;
    srcb_i = 32'hFFFF_FFF9;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("pre_rst_stall", 32'(stall_o), 32'd1);
    resetn = 1'b0;
    #1;
    check("arst_stall", 32'(stall_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_hi", hi_o, 32'd0);
    check("arst_lo", lo_o, 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    alucontrol_i = ADDU_CODE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_stall", 32'(stall_o), 32'd0);
      check("post_rst_done", 32'(done_o), 32'd0);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    check("post_rst_hi", hi_o, 32'd0);
    check("post_rst_lo", lo_o, 32'd0);
    run_op(`MULTU_CONTROL, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
